// File: rtl/dma_priority_arbiter_if.sv
// Pin, register-file and timing-control signals of the DMA priority arbiter.
// Bus handshake: HRQ asks the CPU for the bus; the CPU answers with HLDA. The bus is ours only while HRQ=1 and HLDA=1, and we give it back by dropping HRQ and waiting for HLDA=0.
interface dma_priority_arbiter_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0] DREQ;
  logic [NCH-1:0] softwareReq;
  logic [NCH-1:0] maskReg;
  logic           controllerDisable;
  logic           rotatePriority;
  logic           dreqActiveLow;
  logic           dackActiveHigh;
  logic           HLDA;
  logic           transferDone;
  logic           HRQ;
  logic [NCH-1:0] DACK;
  logic           startService;
  logic [CW-1:0]  activeChannel;
  logic           channelValid;
  logic [NCH-1:0] requestStatus;
  logic [4:0]     fsm_state;

  modport master (
    input  DREQ, softwareReq, maskReg, controllerDisable, rotatePriority,
           dreqActiveLow, dackActiveHigh, HLDA, transferDone,
    output HRQ, DACK, startService, activeChannel, channelValid,
           requestStatus, fsm_state
  );

  modport slave (
    output DREQ, softwareReq, maskReg, controllerDisable, rotatePriority,
           dreqActiveLow, dackActiveHigh, HLDA, transferDone,
    input  HRQ, DACK, startService, activeChannel, channelValid,
           requestStatus, fsm_state
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority resolver and HRQ/HLDA bus sequencer.
// Grants one channel per bus tenure, then releases the bus once that transfer is done.
module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  dma_priority_arbiter_if.master bus
);
  localparam int CW = $clog2(NCH);

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_REQ     = 5'b00010;
  localparam logic [4:0] S_GRANT   = 5'b00100;
  localparam logic [4:0] S_SERVICE = 5'b01000;
  localparam logic [4:0] S_RELEASE = 5'b10000;

  logic [4:0]     state;
  logic [4:0]     state_nx;
  logic [NCH-1:0] req_now;
  logic [NCH-1:0] request_status;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grant_vec;
  logic [CW-1:0]  prio;
  logic [CW-1:0]  base;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  winner;
  logic [CW-1:0]  active_channel;
  logic           hrq;
  logic           start_service;
  logic           channel_valid;
  logic           any_pend;

  assign req_now  = (bus.DREQ ^ {NCH{bus.dreqActiveLow}}) | bus.softwareReq;
  assign pend     = request_status & ~bus.maskReg;
  assign any_pend = |pend;

  // Walk from the lowest-priority slot upward so the highest-priority hit is the last write.
  always_comb begin
    base   = bus.rotatePriority ? prio : '0;
    idx    = '0;
    winner = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = base + CW'(k);
      if (pend[idx]) winner = idx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (any_pend && !bus.controllerDisable) state_nx = S_REQ;
      S_REQ: begin
        if (bus.HLDA)       state_nx = any_pend ? S_GRANT : S_RELEASE;
        else if (!any_pend) state_nx = S_IDLE;
      end
      S_GRANT:   state_nx = S_SERVICE;
      S_SERVICE: if (bus.transferDone) state_nx = S_RELEASE;
      S_RELEASE: if (!bus.HLDA) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      request_status <= '0;
      hrq            <= 1'b0;
      start_service  <= 1'b0;
      channel_valid  <= 1'b0;
      grant_vec      <= '0;
      active_channel <= '0;
      prio           <= '0;
    end else begin
      state          <= state_nx;
      request_status <= req_now;
      hrq            <= (state_nx == S_REQ) || (state_nx == S_GRANT) || (state_nx == S_SERVICE);
      start_service  <= (state_nx == S_GRANT);
      channel_valid  <= (state_nx == S_GRANT) || (state_nx == S_SERVICE);
      // The winner is frozen at HLDA time; later request or mask changes cannot move the grant.
      if ((state == S_REQ) && (state_nx == S_GRANT)) begin
        active_channel <= winner;
        grant_vec      <= {{(NCH-1){1'b0}}, 1'b1} << winner;
      end else if ((state_nx != S_GRANT) && (state_nx != S_SERVICE)) begin
        grant_vec <= '0;
      end
      if ((state == S_SERVICE) && bus.transferDone) begin
        prio <= active_channel + CW'(1);
      end
    end
  end

  assign bus.HRQ           = hrq;
  assign bus.DACK          = bus.dackActiveHigh ? grant_vec : ~grant_vec;
  assign bus.startService  = start_service;
  assign bus.activeChannel = active_channel;
  assign bus.channelValid  = channel_valid;
  assign bus.requestStatus = request_status;
  assign bus.fsm_state     = state;
endmodule
